// File: rtl/l1_vy_hakem_pkg.sv
// Shared types and constants for the L1 instruction/data to bus-controller arbiter.
package l1_vy_hakem_pkg;

    localparam int unsigned ADRES_BIT   = 32;
    localparam int unsigned L1_BLOK_BIT = 128;

    localparam logic PORT_B = 1'b0;
    localparam logic PORT_V = 1'b1;

    typedef enum logic [1:0] {
        HAKEM_BOSTA = 2'd0,
        HAKEM_ISTEK = 2'd1,
        HAKEM_YANIT = 2'd2
    } hakem_durum_e;

endpackage

// File: rtl/rr_hakem_2.sv
// Two-input round-robin grant: on a tie the port that did not win last time wins.
module rr_hakem_2
    import l1_vy_hakem_pkg::*;
(
    input  logic istek_b_i,
    input  logic istek_v_i,
    input  logic son_kazanan_i,
    output logic izin_b_o,
    output logic izin_v_o,
    output logic kazanan_o
);

    logic kazanan;

    always_comb begin
        kazanan = PORT_B;
        if (istek_b_i && istek_v_i) begin
            kazanan = ~son_kazanan_i;
        end else if (istek_v_i) begin
            kazanan = PORT_V;
        end
    end

    assign kazanan_o = kazanan;
    assign izin_b_o  = istek_b_i && (kazanan == PORT_B);
    assign izin_v_o  = istek_v_i && (kazanan == PORT_V);

endmodule

// File: rtl/l1_vy_hakem.sv
// Arbitrates L1 instruction (B) and data (V) requests onto one downstream port,
// one transaction in flight, read response routed back to the owning port.
module l1_vy_hakem
    import l1_vy_hakem_pkg::*;
#(
    parameter int unsigned ADRES_BIT = 32,
    parameter int unsigned BLOK_BIT  = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic [ADRES_BIT-1:0] b_istek_adres_i,
    input  logic                 b_istek_gecerli_i,
    input  logic                 b_istek_yaz_i,
    input  logic [BLOK_BIT-1:0]  b_istek_veri_i,
    output logic                 b_istek_hazir_o,
    output logic [BLOK_BIT-1:0]  b_veri_o,
    output logic                 b_veri_gecerli_o,
    input  logic                 b_veri_hazir_i,

    input  logic [ADRES_BIT-1:0] v_istek_adres_i,
    input  logic                 v_istek_gecerli_i,
    input  logic                 v_istek_yaz_i,
    input  logic [BLOK_BIT-1:0]  v_istek_veri_i,
    output logic                 v_istek_hazir_o,
    output logic [BLOK_BIT-1:0]  v_veri_o,
    output logic                 v_veri_gecerli_o,
    input  logic                 v_veri_hazir_i,

    output logic [ADRES_BIT-1:0] vy_istek_adres_o,
    output logic                 vy_istek_gecerli_o,
    output logic                 vy_istek_yaz_o,
    output logic [BLOK_BIT-1:0]  vy_istek_veri_o,
    input  logic                 vy_istek_hazir_i,
    input  logic [BLOK_BIT-1:0]  vy_veri_i,
    input  logic                 vy_veri_gecerli_i,
    output logic                 vy_veri_hazir_o
);

    hakem_durum_e         durum_q, durum_d;
    logic                 sahip_q, sahip_d;
    logic                 son_kazanan_q, son_kazanan_d;
    logic [ADRES_BIT-1:0] adres_q, adres_d;
    logic                 yaz_q, yaz_d;
    logic [BLOK_BIT-1:0]  veri_q, veri_d;

    logic izin_b, izin_v, kazanan;
    logic sahip_hazir;

    rr_hakem_2 u_rr_hakem_2 (
        .istek_b_i     (b_istek_gecerli_i),
        .istek_v_i     (v_istek_gecerli_i),
        .son_kazanan_i (son_kazanan_q),
        .izin_b_o      (izin_b),
        .izin_v_o      (izin_v),
        .kazanan_o     (kazanan)
    );

    assign sahip_hazir = (sahip_q == PORT_V) ? v_veri_hazir_i : b_veri_hazir_i;

    always_comb begin
        durum_d          = durum_q;
        sahip_d          = sahip_q;
        son_kazanan_d    = son_kazanan_q;
        adres_d          = adres_q;
        yaz_d            = yaz_q;
        veri_d           = veri_q;
        b_istek_hazir_o  = 1'b0;
        v_istek_hazir_o  = 1'b0;
        b_veri_o         = '0;
        b_veri_gecerli_o = 1'b0;
        v_veri_o         = '0;
        v_veri_gecerli_o = 1'b0;
        vy_veri_hazir_o  = 1'b0;

        unique case (durum_q)
            HAKEM_BOSTA: begin
                b_istek_hazir_o = izin_b;
                v_istek_hazir_o = izin_v;
                if (izin_b || izin_v) begin
                    // Winner's fields are captured here; upstream may drop them next cycle.
                    adres_d       = (kazanan == PORT_V) ? v_istek_adres_i : b_istek_adres_i;
                    yaz_d         = (kazanan == PORT_V) ? v_istek_yaz_i : b_istek_yaz_i;
                    veri_d        = (kazanan == PORT_V) ? v_istek_veri_i : b_istek_veri_i;
                    sahip_d       = kazanan;
                    son_kazanan_d = kazanan;
                    durum_d       = HAKEM_ISTEK;
                end
            end
            HAKEM_ISTEK: begin
                if (vy_istek_hazir_i) begin
                    durum_d = yaz_q ? HAKEM_BOSTA : HAKEM_YANIT;
                end
            end
            HAKEM_YANIT: begin
                vy_veri_hazir_o = sahip_hazir;
                if (sahip_q == PORT_V) begin
                    v_veri_o         = vy_veri_i;
                    v_veri_gecerli_o = vy_veri_gecerli_i;
                end else begin
                    b_veri_o         = vy_veri_i;
                    b_veri_gecerli_o = vy_veri_gecerli_i;
                end
                if (vy_veri_gecerli_i && sahip_hazir) begin
                    durum_d = HAKEM_BOSTA;
                end
            end
            default: durum_d = HAKEM_BOSTA;
        endcase
    end

    assign vy_istek_gecerli_o = (durum_q == HAKEM_ISTEK);
    assign vy_istek_adres_o   = adres_q;
    assign vy_istek_yaz_o     = yaz_q;
    assign vy_istek_veri_o    = veri_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q       <= HAKEM_BOSTA;
            sahip_q       <= PORT_B;
            son_kazanan_q <= PORT_V;
            adres_q       <= '0;
            yaz_q         <= 1'b0;
            veri_q        <= '0;
        end else begin
            durum_q       <= durum_d;
            sahip_q       <= sahip_d;
            son_kazanan_q <= son_kazanan_d;
            adres_q       <= adres_d;
            yaz_q         <= yaz_d;
            veri_q        <= veri_d;
        end
    end

endmodule

// File: doc/l1_vy_hakem.md
Name: l1_vy_hakem

Overview:
- Two-port arbiter between the L1 instruction-cache controller and the L1 data-cache controller; single master output feeds the L1-side port of veri_yolu_denetleyici.
- Registers the winning request, forwards it downstream, tracks the single outstanding transaction, and routes the read response back to the owning port.
- Round-robin arbitration; exactly one transaction in flight.

Parameters:
- ADRES_BIT, 32, request address width.
- BLOK_BIT, 128, L1 block width (request write data and response data).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- b_istek_adres_i  in  ADRES_BIT  instruction port request address.
- b_istek_gecerli_i  in  1  instruction port request valid.
- b_istek_yaz_i  in  1  instruction port write (1) / read (0).
- b_istek_veri_i  in  BLOK_BIT  instruction port write block.
- b_istek_hazir_o  out  1  instruction port request accepted.
- b_veri_o  out  BLOK_BIT  instruction port response block.
- b_veri_gecerli_o  out  1  instruction port response valid.
- b_veri_hazir_i  in  1  instruction port can take response.
- v_*: same eight signals as b_*, for the data port.
- vy_istek_adres_o  out  ADRES_BIT  downstream address.
- vy_istek_gecerli_o  out  1  downstream request valid.
- vy_istek_yaz_o  out  1  downstream write.
- vy_istek_veri_o  out  BLOK_BIT  downstream write block.
- vy_istek_hazir_i  in  1  downstream accepts request.
- vy_veri_i  in  BLOK_BIT  downstream response block.
- vy_veri_gecerli_i  in  1  downstream response valid.
- vy_veri_hazir_o  out  1  response ready to downstream.

Behaviour:
- FSM states: BOSTA, ISTEK, YANIT. Reset → BOSTA, sahip=B, son_kazanan=V (B wins the first tie). vy_istek_* registers cleared to 0.
- Reset values: all *_hazir_o, *_gecerli_o = 0; all data/address outputs = 0.
- BOSTA:
  - If exactly one port has gecerli, that port wins.
  - If both have gecerli, the port != son_kazanan wins.
  - Winner's istek_hazir_o = 1, combinationally, in the same cycle. The loser's hazir = 0.
  - On that edge: latch adres/yaz/veri, sahip ← winner, son_kazanan ← winner, go to ISTEK.
  - With no valid request, stay in BOSTA.
- ISTEK:
  - vy_istek_gecerli_o = 1 with latched fields held stable.
  - On vy_istek_hazir_i = 1: a write returns to BOSTA; a read goes to YANIT.
  - Upstream istek_hazir_o = 0 in this state.
- YANIT:
  - sahip's veri_o = vy_veri_i and veri_gecerli_o = vy_veri_gecerli_i, both combinational.
  - vy_veri_hazir_o = sahip's veri_hazir_i.
  - On vy_veri_gecerli_i && hazir → BOSTA.
  - The non-owner's veri_gecerli_o = 0 always; its veri_o = 0.
- vy_veri_gecerli_i outside YANIT is ignored; vy_veri_hazir_o = 0 outside YANIT.
- Latency:
  - Upstream accept edge → vy_istek_gecerli_o high next cycle (1 cycle).
  - Response path: 0 cycles.
  - Minimum back-to-back: a new grant occurs in the cycle after return to BOSTA.
- Fairness: under continuous contention, grants alternate B,V,B,V. A requester waits at most one foreign transaction.
- Reset mid-transaction: outstanding transaction dropped, FSM → BOSTA, no response forwarded. Upstream controllers are reset on the same rst_i.
- Upstream requests must hold stable while gecerli=1 and hazir=0. The arbiter samples only on the accept edge.

Decomposition:
- Shared package/header: state encodings HAKEM_BOSTA/ISTEK/YANIT (2 bits), port IDs PORT_B=0 / PORT_V=1, plus existing ADRES_BIT / L1_BLOK_BIT constants.
- Optional sub-module rr_hakem_2: 2-input round-robin grant logic, combinational, with a son_kazanan register input. Everything else stays in l1_vy_hakem.

Test Plan:
- Single read from B: adres 0x0000_0040 → b_istek_hazir_o high the same cycle; vy_istek_gecerli_o high the next cycle with adres 0x40, yaz=0. After vy_veri_gecerli_i with 0xDEAD…BEEF, b_veri_gecerli_o=1 with that data and v_veri_gecerli_o=0.
- Simultaneous B and V reads after reset → B granted first, V second. Continuous contention for 4 transactions → grant order B,V,B,V.
- V write with vy_istek_hazir_i held low for 5 cycles → vy_istek_gecerli_o stays high with adres/veri stable. On hazir the FSM returns to BOSTA, no response is awaited, and the next grant is possible the cycle after.
- Response backpressure: owner V holds v_veri_hazir_i=0 for 3 cycles while vy_veri_gecerli_i=1 → vy_veri_hazir_o=0 for those cycles; the transaction completes on the first cycle both are high.
- Spurious vy_veri_gecerli_i=1 in BOSTA → no b/v_veri_gecerli_o asserted, no state change.
- rst_i asserted in YANIT → next cycle all outputs 0, FSM BOSTA. A following B request is granted normally, since son_kazanan resets to V.
